// File: rtl/multdiv_ctrl_if.sv
// Signal bundle between execute, the iterative multdiv unit and writeback for multdiv_ctrl.
// The controller takes the master view; the surrounding pipeline/unit side takes the slave view.
interface multdiv_ctrl_if;
    logic        ex_valid;
    logic        ex_is_mult;
    logic        ex_is_div;
    logic [31:0] ex_opA;
    logic [31:0] ex_opB;
    logic [4:0]  ex_rd;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    modport master (
        input  ex_valid, ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd,
        input  md_result, md_exception, md_resultRDY,
        output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output stall, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport slave (
        output ex_valid, ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd,
        output md_result, md_exception, md_resultRDY,
        input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  stall, wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the iterative multdiv unit: latches the op, pulses start once,
// stalls while the unit iterates and emits one writeback packet. Optional BUSY timeout: `MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
    parameter logic [4:0]  RSTATUS_REG    = 5'd30,
    parameter logic [31:0] MULT_EXC_CODE  = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE   = 32'd5,
    parameter int unsigned TIMEOUT_CYCLES = 48
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;

`ifdef MULTDIV_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif
    localparam logic [5:0] TimeoutLast = 6'(TIMEOUT_CYCLES - 1);

    state_e      state_q,   state_d;
    logic [31:0] opA_q,     opA_d;
    logic [31:0] opB_q,     opB_d;
    logic [4:0]  rd_q,      rd_d;
    logic        isMult_q,  isMult_d;
    logic [4:0]  wbRd_q,    wbRd_d;
    logic [31:0] wbData_q,  wbData_d;
    logic        wbExc_q,   wbExc_d;
    logic [5:0]  busyCnt_q, busyCnt_d;

    logic        accept;
    logic        timedOut;
    logic [31:0] excCode;

    assign accept   = bus.ex_valid && (bus.ex_is_mult || bus.ex_is_div);
    assign excCode  = isMult_q ? MULT_EXC_CODE : DIV_EXC_CODE;
    assign timedOut = TimeoutEn && (busyCnt_q == TimeoutLast);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            rd_q      <= '0;
            isMult_q  <= 1'b0;
            wbRd_q    <= '0;
            wbData_q  <= '0;
            wbExc_q   <= 1'b0;
            busyCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            rd_q      <= rd_d;
            isMult_q  <= isMult_d;
            wbRd_q    <= wbRd_d;
            wbData_q  <= wbData_d;
            wbExc_q   <= wbExc_d;
            busyCnt_q <= busyCnt_d;
        end
    end

    // Ready strobes are only honoured in BUSY; the busy counter restarts from zero on every BUSY entry.
    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        rd_d      = rd_q;
        isMult_d  = isMult_q;
        wbRd_d    = wbRd_q;
        wbData_d  = wbData_q;
        wbExc_d   = wbExc_q;
        busyCnt_d = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    opA_d    = bus.ex_opA;
                    opB_d    = bus.ex_opB;
                    rd_d     = bus.ex_rd;
                    isMult_d = bus.ex_is_mult;
                    state_d  = START;
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (TimeoutEn) begin
                    busyCnt_d = busyCnt_q + 6'd1;
                end
                if (bus.md_resultRDY) begin
                    state_d = DONE;
                    if (bus.md_exception) begin
                        wbRd_d   = RSTATUS_REG;
                        wbData_d = excCode;
                        wbExc_d  = 1'b1;
                    end else begin
                        wbRd_d   = rd_q;
                        wbData_d = bus.md_result;
                        wbExc_d  = 1'b0;
                    end
                end else if (timedOut) begin
                    state_d  = DONE;
                    wbRd_d   = RSTATUS_REG;
                    wbData_d = excCode;
                    wbExc_d  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands come from the latched copies in every state so the unit never sees execute change under it.
    assign bus.md_operandA  = opA_q;
    assign bus.md_operandB  = opB_q;
    assign bus.md_ctrl_MULT = (state_q == START) && isMult_q;
    assign bus.md_ctrl_DIV  = (state_q == START) && !isMult_q;
    assign bus.stall        = ((state_q == IDLE) && accept) || (state_q == START) || (state_q == BUSY);
    assign bus.wb_valid     = (state_q == DONE);
    assign bus.wb_rd        = wbRd_q;
    assign bus.wb_data      = wbData_q;
    assign bus.wb_exception = wbExc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: a behavioural multdiv unit with configurable latency and
// spurious ready strobes, plus an arithmetic reference for the expected writeback packet.
`timescale 1ns/1ps
module tb_multdiv_ctrl;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multdiv_ctrl_if bus ();

    multdiv_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    bit          unitMute = 1'b0;
    bit          spurEn   = 1'b1;
    int          nextLat  = 4;
    int          unitLeft = 0;
    bit          pending  = 1'b0;
    logic [31:0] unitRes;
    logic        unitExc;

    function automatic void mdCompute(input bit isMult, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic exc);
        logic signed [63:0] p;
        if (isMult) begin
            p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            res = $signed(a) / $signed(b);
            exc = 1'b0;
        end
    endfunction

    function automatic void refWb(input bit isMult, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, output logic [4:0] eRd,
                                  output logic [31:0] eData, output logic eExc);
        logic [31:0] r;
        logic        x;
        mdCompute(isMult, a, b, r, x);
        if (x) begin
            eRd   = 5'd30;
            eData = isMult ? 32'd4 : 32'd5;
            eExc  = 1'b1;
        end else begin
            eRd   = rd;
            eData = r;
            eExc  = 1'b0;
        end
    endfunction

    // Unit model: samples operands on the start pulse, answers after nextLat cycles (divide-by-zero at once).
    always @(negedge clock) begin
        if (unitMute) begin
            pending          = 1'b0;
            bus.md_resultRDY = 1'b0;
            bus.md_result    = 32'd0;
            bus.md_exception = 1'b0;
        end else if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
            mdCompute(bus.md_ctrl_MULT, bus.md_operandA, bus.md_operandB, unitRes, unitExc);
            unitLeft         = (!bus.md_ctrl_MULT && bus.md_operandB == 32'd0) ? 1 : nextLat;
            pending          = 1'b1;
            bus.md_resultRDY = spurEn && ($urandom_range(0, 1) == 1);
            bus.md_result    = $urandom;
            bus.md_exception = 1'($urandom_range(0, 1));
        end else if (pending) begin
            unitLeft = unitLeft - 1;
            if (unitLeft <= 0) begin
                pending          = 1'b0;
                bus.md_resultRDY = 1'b1;
                bus.md_result    = unitRes;
                bus.md_exception = unitExc;
            end else begin
                bus.md_resultRDY = 1'b0;
                bus.md_result    = $urandom;
                bus.md_exception = 1'($urandom_range(0, 1));
            end
        end else begin
            bus.md_resultRDY = spurEn && ($urandom_range(0, 3) == 0);
            bus.md_result    = $urandom;
            bus.md_exception = 1'($urandom_range(0, 1));
        end
    end

    task automatic issueOp(input bit isMult, input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int lat, input int changeAt, input int tail,
                           output int wbLat, output int nWb, output logic [4:0] oRd,
                           output logic [31:0] oData, output logic oExc, output int nMult,
                           output int nDiv, output int stallErr, output int opErr);
        int cyc;
        bit done;
        nextLat = lat;
        wbLat = 0; nWb = 0; nMult = 0; nDiv = 0; stallErr = 0; opErr = 0;
        oRd = '0; oData = '0; oExc = 1'b0;
        @(negedge clock);
        bus.ex_valid = 1'b1; bus.ex_is_mult = isMult; bus.ex_is_div = isDiv;
        bus.ex_opA = a; bus.ex_opB = b; bus.ex_rd = rd;
        #1;
        if (bus.stall !== 1'b1) stallErr++;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (bus.md_ctrl_MULT === 1'b1) nMult++;
            if (bus.md_ctrl_DIV === 1'b1) nDiv++;
            if (bus.md_operandA !== a || bus.md_operandB !== b) opErr++;
            if (bus.wb_valid === 1'b1) begin
                nWb++; wbLat = cyc; done = 1'b1;
                oRd = bus.wb_rd; oData = bus.wb_data; oExc = bus.wb_exception;
                if (bus.stall !== 1'b0) stallErr++;
            end else if (bus.stall !== 1'b1) begin
                stallErr++;
            end
            if (cyc == changeAt) begin
                bus.ex_opA = $urandom;
                bus.ex_opB = $urandom | 32'd1;
            end
        end
        @(posedge clock);
        #1;
        bus.ex_valid = 1'b0;
        for (int i = 0; i < tail; i++) begin
            @(negedge clock);
            if (bus.md_ctrl_MULT === 1'b1) nMult++;
            if (bus.md_ctrl_DIV === 1'b1) nDiv++;
            if (bus.wb_valid === 1'b1) nWb++;
            if (bus.stall !== 1'b0) stallErr++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs [9];
        string       nm  [9];
        reset = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_is_mult = 1'b0; bus.ex_is_div = 1'b0;
        bus.ex_opA = '0; bus.ex_opB = '0; bus.ex_rd = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        obs[0] = 32'(bus.stall);        nm[0] = "reset_stall";
        obs[1] = 32'(bus.wb_valid);     nm[1] = "reset_wb_valid";
        obs[2] = 32'(bus.wb_exception); nm[2] = "reset_wb_exception";
        obs[3] = 32'(bus.wb_rd);        nm[3] = "reset_wb_rd";
        obs[4] = bus.wb_data;           nm[4] = "reset_wb_data";
        obs[5] = 32'(bus.md_ctrl_MULT); nm[5] = "reset_ctrl_mult";
        obs[6] = 32'(bus.md_ctrl_DIV);  nm[6] = "reset_ctrl_div";
        obs[7] = bus.md_operandA;       nm[7] = "reset_operandA";
        obs[8] = bus.md_operandB;       nm[8] = "reset_operandB";
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs[i] !== 32'd0) begin
                errors++;
                $display("[TB] FAIL %s: got %h expected 0", nm[i], obs[i]);
            end
        end
    endtask

    task automatic test_mul_basic();
        int wbLat, nWb, nMult, nDiv, stallErr, opErr;
        logic [4:0] oRd; logic [31:0] oData; logic oExc;
        issueOp(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 4, 0, 3,
                wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
        checks++;
        if (nMult !== 1 || nDiv !== 0) begin
            errors++; $display("[TB] FAIL mul_pulse: got mult %0d div %0d expected 1 0", nMult, nDiv);
        end
        checks++;
        if (stallErr !== 0 || opErr !== 0) begin
            errors++; $display("[TB] FAIL mul_stall_ops: got stallErr %0d opErr %0d expected 0 0", stallErr, opErr);
        end
        checks++;
        if (nWb !== 1 || wbLat !== 6) begin
            errors++; $display("[TB] FAIL mul_wb_timing: got n %0d lat %0d expected 1 6", nWb, wbLat);
        end
        checks++;
        if (oRd !== 5'd5 || oData !== 32'hFFFF_FFEB || oExc !== 1'b0) begin
            errors++; $display("[TB] FAIL mul_wb: got rd %0d data %h exc %b expected 5 ffffffeb 0", oRd, oData, oExc);
        end
    endtask

    task automatic test_div_operand_hold();
        int wbLat, nWb, nMult, nDiv, stallErr, opErr;
        logic [4:0] oRd; logic [31:0] oData; logic oExc;
        issueOp(1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3, 5'd9, 8, 4, 3,
                wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
        checks++;
        if (opErr !== 0) begin
            errors++; $display("[TB] FAIL div_operand_hold: got %0d bad operand cycles expected 0", opErr);
        end
        checks++;
        if (nDiv !== 1 || nMult !== 0 || stallErr !== 0) begin
            errors++; $display("[TB] FAIL div_ctrl: got div %0d mult %0d stallErr %0d expected 1 0 0", nDiv, nMult, stallErr);
        end
        checks++;
        if (nWb !== 1 || wbLat !== 10 || oRd !== 5'd9 || oData !== 32'hFFFF_FFFA || oExc !== 1'b0) begin
            errors++; $display("[TB] FAIL div_wb: got n %0d lat %0d rd %0d data %h exc %b expected 1 10 9 fffffffa 0",
                               nWb, wbLat, oRd, oData, oExc);
        end
    endtask

    task automatic test_div_by_zero();
        int wbLat, nWb, nMult, nDiv, stallErr, opErr;
        logic [4:0] oRd; logic [31:0] oData; logic oExc;
        issueOp(1'b0, 1'b1, 32'd100, 32'd0, 5'd12, 10, 0, 3,
                wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
        checks++;
        if (nWb !== 1 || wbLat !== 3 || stallErr !== 0) begin
            errors++; $display("[TB] FAIL divzero_timing: got n %0d lat %0d stallErr %0d expected 1 3 0", nWb, wbLat, stallErr);
        end
        checks++;
        if (oRd !== 5'd30 || oData !== 32'd5 || oExc !== 1'b1) begin
            errors++; $display("[TB] FAIL divzero_wb: got rd %0d data %h exc %b expected 30 5 1", oRd, oData, oExc);
        end
    endtask

    task automatic test_mul_overflow();
        int wbLat, nWb, nMult, nDiv, stallErr, opErr;
        logic [4:0] oRd; logic [31:0] oData; logic oExc;
        issueOp(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd17, 6, 0, 3,
                wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
        checks++;
        if (nWb !== 1 || wbLat !== 8 || oRd !== 5'd30 || oData !== 32'd4 || oExc !== 1'b1) begin
            errors++; $display("[TB] FAIL mul_overflow: got n %0d lat %0d rd %0d data %h exc %b expected 1 8 30 4 1",
                               nWb, wbLat, oRd, oData, oExc);
        end
    endtask

    task automatic test_reset_mid();
        int wbLat, nWb, nMult, nDiv, stallErr, opErr, wbSeen, stallSeen;
        logic [4:0] oRd; logic [31:0] oData; logic oExc;
        nextLat = 20;
        @(negedge clock);
        bus.ex_valid = 1'b1; bus.ex_is_mult = 1'b0; bus.ex_is_div = 1'b1;
        bus.ex_opA = 32'hFFFF_FFCE; bus.ex_opB = 32'd7; bus.ex_rd = 5'd3;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        bus.ex_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid_stall: got stall %b wb_valid %b expected 0 0", bus.stall, bus.wb_valid);
        end
        wbSeen = 0; stallSeen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.wb_valid !== 1'b0) wbSeen++;
            if (bus.stall !== 1'b0) stallSeen++;
        end
        checks++;
        if (wbSeen !== 0 || stallSeen !== 0) begin
            errors++; $display("[TB] FAIL reset_mid_quiet: got wb %0d stall %0d cycles expected 0 0", wbSeen, stallSeen);
        end
        issueOp(1'b1, 1'b0, 32'd6, 32'd7, 5'd4, 3, 0, 2,
                wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
        checks++;
        if (nWb !== 1 || wbLat !== 5 || oRd !== 5'd4 || oData !== 32'd42 || oExc !== 1'b0 || nMult !== 1) begin
            errors++; $display("[TB] FAIL reset_mid_next_mul: got n %0d lat %0d rd %0d data %h exc %b pulses %0d expected 1 5 4 2a 0 1",
                               nWb, wbLat, oRd, oData, oExc, nMult);
        end
    endtask

    task automatic test_back_to_back();
        int wbLat, nWb, nMult, nDiv, stallErr, opErr;
        logic [4:0] oRd, eRd; logic [31:0] oData, eData, a, b; logic oExc, eExc;
        for (int k = 0; k < 4; k++) begin
            a = 32'(int'($urandom_range(0, 4000)) - 2000);
            b = 32'(int'($urandom_range(1, 300)));
            refWb(k[0], a, b, 5'(k + 1), eRd, eData, eExc);
            issueOp(k[0], !k[0], a, b, 5'(k + 1), k + 2, 0, 0,
                    wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
            checks++;
            if (nWb !== 1 || wbLat !== k + 4 || oRd !== eRd || oData !== eData || oExc !== eExc || stallErr !== 0) begin
                errors++; $display("[TB] FAIL b2b[%0d]: got n %0d lat %0d rd %0d data %h exc %b stallErr %0d expected 1 %0d %0d %h %b 0",
                                   k, nWb, wbLat, oRd, oData, oExc, stallErr, k + 4, eRd, eData, eExc);
            end
        end
    endtask

    task automatic test_random();
        int wbLat, nWb, nMult, nDiv, stallErr, opErr, mode, lat, expLat;
        logic [4:0] oRd, eRd, rd; logic [31:0] oData, eData, a, b; logic oExc, eExc;
        bit isMult, isDiv, effMult;
        for (int k = 0; k < 24; k++) begin
            mode = $urandom_range(0, 3);
            a = $urandom; b = $urandom; rd = 5'($urandom);
            if (mode == 0) begin
                a = 32'(int'($urandom_range(0, 2000)) - 1000);
                b = 32'(int'($urandom_range(0, 2000)) - 1000);
            end
            if (mode == 2) b = 32'd0;
            isMult = 1'($urandom_range(0, 1));
            isDiv  = !isMult;
            if (mode == 3) begin isMult = 1'b1; isDiv = 1'b1; end
            effMult = isMult;
            if (!effMult && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            lat = $urandom_range(1, 12);
            expLat = (!effMult && b == 32'd0) ? 3 : lat + 2;
            refWb(effMult, a, b, rd, eRd, eData, eExc);
            issueOp(isMult, isDiv, a, b, rd, lat, 0, 2,
                    wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
            checks++;
            if (nWb !== 1 || wbLat !== expLat || oRd !== eRd || oData !== eData || oExc !== eExc) begin
                errors++; $display("[TB] FAIL random[%0d]_wb: got n %0d lat %0d rd %0d data %h exc %b expected 1 %0d %0d %h %b",
                                   k, nWb, wbLat, oRd, oData, oExc, expLat, eRd, eData, eExc);
            end
            checks++;
            if (nMult !== int'(effMult) || nDiv !== int'(!effMult) || stallErr !== 0 || opErr !== 0) begin
                errors++; $display("[TB] FAIL random[%0d]_ctrl: got mult %0d div %0d stallErr %0d opErr %0d expected %0d %0d 0 0",
                                   k, nMult, nDiv, stallErr, opErr, int'(effMult), int'(!effMult));
            end
        end
    endtask

    task automatic test_timeout();
`ifdef MULTDIV_TIMEOUT_EN
        int wbLat, nWb, nMult, nDiv, stallErr, opErr;
        logic [4:0] oRd; logic [31:0] oData; logic oExc;
        unitMute = 1'b1;
        issueOp(1'b1, 1'b0, 32'd3, 32'd5, 5'd7, 4, 0, 2,
                wbLat, nWb, oRd, oData, oExc, nMult, nDiv, stallErr, opErr);
        checks++;
        if (nWb !== 1 || wbLat !== 50 || oRd !== 5'd30 || oData !== 32'd4 || oExc !== 1'b1 || stallErr !== 0) begin
            errors++; $display("[TB] FAIL timeout_wb: got n %0d lat %0d rd %0d data %h exc %b stallErr %0d expected 1 50 30 4 1 0",
                               nWb, wbLat, oRd, oData, oExc, stallErr);
        end
`else
        int highCnt, wbCnt;
        unitMute = 1'b1;
        @(negedge clock);
        bus.ex_valid = 1'b1; bus.ex_is_mult = 1'b1; bus.ex_is_div = 1'b0;
        bus.ex_opA = 32'd3; bus.ex_opB = 32'd5; bus.ex_rd = 5'd7;
        highCnt = 0; wbCnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.stall === 1'b1) highCnt++;
            if (bus.wb_valid !== 1'b0) wbCnt++;
        end
        checks++;
        if (highCnt !== 200 || wbCnt !== 0) begin
            errors++; $display("[TB] FAIL no_timeout_hang: got stall %0d wb %0d expected 200 0", highCnt, wbCnt);
        end
        reset = 1'b1;
        bus.ex_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL no_timeout_recover: got stall %b expected 0", bus.stall);
        end
`endif
        unitMute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_div_operand_hold();
        test_div_by_zero();
        test_mul_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
